// File: rtl/cpu_timing_interrupt_seq_pkg.sv
// rtl/cpu_timing_interrupt_seq_pkg.sv - opcode, B-bit and sequence-end constants for the timing sequencer
package cpu_timing_interrupt_seq_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_ADD    = 3'd1,
    OP_LDA    = 3'd2,
    OP_STA    = 3'd3,
    OP_BUN    = 3'd4,
    OP_BSA    = 3'd5,
    OP_ISZ    = 3'd6,
    OP_REG_IO = 3'd7
  } opcode_e;

  localparam int B_HLT = 0;
  localparam int B_SZE = 1;
  localparam int B_SZA = 2;
  localparam int B_SNA = 3;
  localparam int B_SPA = 4;
  localparam int B_IOF = 6;
  localparam int B_ION = 7;
  localparam int B_SKO = 8;
  localparam int B_SKI = 9;
  localparam int B_OUT = 10;
  localparam int B_INP = 11;

  localparam logic [2:0] T_END_INT   = 3'd2;
  localparam logic [2:0] T_END_REG   = 3'd3;
  localparam logic [2:0] T_END_SHORT = 3'd4;
  localparam logic [2:0] T_END_MEM   = 3'd5;
  localparam logic [2:0] T_END_ISZ   = 3'd6;

  // Timing state at which each instruction returns the sequence counter to T0.
  function automatic logic [2:0] end_time(opcode_e op);
    case (op)
      OP_AND, OP_ADD, OP_LDA, OP_BSA: return T_END_MEM;
      OP_STA, OP_BUN:                 return T_END_SHORT;
      OP_ISZ:                         return T_END_ISZ;
      default:                        return T_END_REG;
    endcase
  endfunction

endpackage

// File: rtl/io_flag_hs.sv
// rtl/io_flag_hs.sv - FGI/FGO flags with keyboard and printer ready/valid handshakes
module io_flag_hs (
  input  logic clk,
  input  logic rst,
  input  logic inp_clr,
  input  logic out_load,
  input  logic in_valid,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic fgi,
  output logic fgo
);

  assign in_ready = ~fgi;

  always_ff @(posedge clk) begin
    if (rst) begin
      fgi       <= 1'b0;
      fgo       <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      // INP only executes while FGI=1, when no byte can be accepted.
      if (inp_clr)
        fgi <= 1'b0;
      else if (in_valid && in_ready)
        fgi <= 1'b1;

      if (out_load) begin
        fgo       <= 1'b0;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        fgo       <= 1'b1;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cpu_timing_interrupt_seq.sv
// rtl/cpu_timing_interrupt_seq.sv - sequence counter, opcode latch, interrupt cycle and start/stop control
module cpu_timing_interrupt_seq #(
  parameter int   SC_W      = 3,
  parameter logic START_RUN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ir_op,
  input  logic        ir_i,
  input  logic [11:0] ir_b,
  input  logic        ac_sign,
  input  logic        ac_zero,
  input  logic        e_flag,
  input  logic        dr_zero,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  T,
  output logic [7:0]  D,
  output logic        I,
  output logic        R,
  output logic        IEN,
  output logic        FGI,
  output logic        FGO,
  output logic        S,
  output logic        skip
);
  import cpu_timing_interrupt_seq_pkg::*;

  localparam int NT = 1 << SC_W;
  localparam logic [NT-1:0] ONE = NT'(1);

  logic [SC_W-1:0] sc;
  logic [NT-1:0]   t_vec, d_q, t_end;
  logic            i_q, r_q, ien_q, s_q;
  logic            fgi, fgo;
  logic            reg_ref, io_ref, clr, int_done, fetch, r_set;
  logic            hlt, inp, out_cmd, ion, iof;
  logic            unused_b5;

  assign t_vec = s_q ? (ONE << sc) : '0;

  assign reg_ref  = d_q[OP_REG_IO] & ~i_q & t_vec[T_END_REG];
  assign io_ref   = d_q[OP_REG_IO] &  i_q & t_vec[T_END_REG];
  assign hlt      = reg_ref & ir_b[B_HLT];
  assign inp      = io_ref & ir_b[B_INP];
  assign out_cmd  = io_ref & ir_b[B_OUT];
  assign ion      = io_ref & ir_b[B_ION];
  assign iof      = io_ref & ir_b[B_IOF];
  assign int_done = r_q & t_vec[T_END_INT];
  assign fetch    = ~r_q & t_vec[2];
  // Interrupt entry waits until the fetch of the current instruction is over.
  assign r_set    = s_q & ~r_q & ~(|t_vec[2:0]) & ien_q & (fgi | fgo);
  assign unused_b5 = ir_b[5];

  always_comb begin
    t_end = '0;
    for (int k = 0; k < NT; k++)
      t_end[k] = t_vec[end_time(opcode_e'(k[2:0]))];
  end

  assign clr = int_done | (|(d_q & t_end));

  assign skip = (reg_ref & ((ir_b[B_SPA] & ~ac_sign) | (ir_b[B_SNA] & ac_sign) |
                            (ir_b[B_SZA] & ac_zero)  | (ir_b[B_SZE] & ~e_flag))) |
                (io_ref  & ((ir_b[B_SKI] & fgi) | (ir_b[B_SKO] & fgo))) |
                (d_q[OP_ISZ] & t_vec[T_END_ISZ] & dr_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      sc    <= '0;
      s_q   <= START_RUN;
      r_q   <= 1'b0;
      ien_q <= 1'b0;
      d_q   <= '0;
      i_q   <= 1'b0;
    end else if (!s_q) begin
      if (start) begin
        s_q <= 1'b1;
        sc  <= '0;
      end
    end else begin
      sc <= clr ? '0 : sc + SC_W'(1);
      if (hlt)
        s_q <= 1'b0;
      if (fetch) begin
        d_q <= ONE << ir_op;
        i_q <= ir_i;
      end
      if (r_set)
        r_q <= 1'b1;
      else if (int_done)
        r_q <= 1'b0;
      if (int_done || iof)
        ien_q <= 1'b0;
      else if (ion)
        ien_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && s_q && (&sc))
      assert (clr);
  end

  io_flag_hs u_io (
    .clk      (clk),
    .rst      (rst),
    .inp_clr  (inp),
    .out_load (out_cmd),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fgi      (fgi),
    .fgo      (fgo)
  );

  assign T   = t_vec;
  assign D   = d_q;
  assign I   = i_q;
  assign R   = r_q;
  assign IEN = ien_q;
  assign FGI = fgi;
  assign FGO = fgo;
  assign S   = s_q;

endmodule

// File: tb/tb_cpu_timing_interrupt_seq.sv
// tb/tb_cpu_timing_interrupt_seq.sv - directed self-checking bench for cpu_timing_interrupt_seq
module tb_cpu_timing_interrupt_seq;

  logic        clk = 1'b0;
  logic        rst, ir_i, ac_sign, ac_zero, e_flag, dr_zero, start, in_valid, out_ready;
  logic [2:0]  ir_op;
  logic [11:0] ir_b;
  logic        in_ready, out_valid, I, R, IEN, FGI, FGO, S, skip;
  logic [7:0]  T, D;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  cpu_timing_interrupt_seq dut (
    .clk(clk), .rst(rst), .ir_op(ir_op), .ir_i(ir_i), .ir_b(ir_b),
    .ac_sign(ac_sign), .ac_zero(ac_zero), .e_flag(e_flag), .dr_zero(dr_zero),
    .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .T(T), .D(D), .I(I), .R(R), .IEN(IEN), .FGI(FGI), .FGO(FGO), .S(S), .skip(skip)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_t0();
    for (int k = 0; k < 20 && T !== 8'h01; k++) tick();
    total++; if (T !== 8'h01) begin bad++; $display("FAIL sync_t0: got %h want 01", T); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (T !== 8'h01) begin bad++; $display("FAIL reset_t: got %h want 01", T); end
    total++; if ({D, I, R, IEN} !== 11'h000) begin bad++; $display("FAIL reset_dir: got %h want 000", {D, I, R, IEN}); end
    total++; if ({FGI, FGO, S, out_valid, skip, in_ready} !== 6'b011001) begin bad++; $display("FAIL reset_flags: got %b want 011001", {FGI, FGO, S, out_valid, skip, in_ready}); end
  endtask

  task automatic test_lda_walk();
    logic [7:0] exp_t [6] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h01};
    ir_op = 3'd2; ir_i = 1'b0; ir_b = 12'h000;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (T !== exp_t[k]) begin bad++; $display("FAIL lda_t%0d: got %h want %h", k + 1, T, exp_t[k]); end
      if (k == 2) begin
        total++; if (D !== 8'h04) begin bad++; $display("FAIL lda_d: got %h want 04", D); end
      end
    end
  endtask

  task automatic test_reg_skip();
    ir_op = 3'd7; ir_i = 1'b0; ir_b = 12'h004; ac_zero = 1'b1; ac_sign = 1'b0;
    repeat (3) tick();
    total++; if ({T, D, skip} !== {8'h08, 8'h80, 1'b1}) begin bad++; $display("FAIL sza_skip: got T=%h D=%h skip=%b want 08 80 1", T, D, skip); end
    tick();
    total++; if ({T, skip} !== {8'h01, 1'b0}) begin bad++; $display("FAIL sza_next: got T=%h skip=%b want 01 0", T, skip); end
    ir_b = 12'h008;
    repeat (3) tick();
    total++; if ({T, skip} !== {8'h08, 1'b0}) begin bad++; $display("FAIL sna_noskip: got T=%h skip=%b want 08 0", T, skip); end
    tick();
    ac_zero = 1'b0;
  endtask

  task automatic test_hlt_start();
    ir_op = 3'd7; ir_i = 1'b0; ir_b = 12'h001;
    repeat (4) tick();
    ir_b = 12'h000;
    total++; if ({S, T} !== 9'h000) begin bad++; $display("FAIL hlt_stop: got S=%b T=%h want 0 00", S, T); end
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (T !== 8'h00) begin bad++; $display("FAIL hlt_hold%0d: got %h want 00", k, T); end
    end
    start = 1'b1; tick(); start = 1'b0;
    total++; if ({S, T} !== 9'h101) begin bad++; $display("FAIL start_run: got S=%b T=%h want 1 01", S, T); end
    start = 1'b1; tick(); start = 1'b0;
    total++; if (T !== 8'h02) begin bad++; $display("FAIL start_ignored: got %h want 02", T); end
    run_to_t0();
  endtask

  task automatic test_interrupt();
    ir_op = 3'd7; ir_i = 1'b1; ir_b = 12'h400; out_ready = 1'b0;
    repeat (4) tick();
    total++; if ({FGO, out_valid, T} !== {2'b01, 8'h01}) begin bad++; $display("FAIL out_start: got FGO=%b ov=%b T=%h want 0 1 01", FGO, out_valid, T); end
    ir_b = 12'h080;
    repeat (3) tick();
    total++; if (IEN !== 1'b0) begin bad++; $display("FAIL ion_early: got %b want 0", IEN); end
    tick();
    total++; if ({IEN, R, T} !== {2'b10, 8'h01}) begin bad++; $display("FAIL ion_set: got IEN=%b R=%b T=%h want 1 0 01", IEN, R, T); end
    ir_op = 3'd2; ir_i = 1'b0;
    repeat (4) tick();
    total++; if ({R, T} !== {1'b0, 8'h10}) begin bad++; $display("FAIL int_t4: got R=%b T=%h want 0 10", R, T); end
    in_valid = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if ({FGI, in_ready, R, T} !== {3'b100, 8'h20}) begin bad++; $display("FAIL in_accept: got FGI=%b rdy=%b R=%b T=%h want 1 0 0 20", FGI, in_ready, R, T); end
    ir_op = 3'd3;
    tick();
    total++; if ({R, T} !== {1'b1, 8'h01}) begin bad++; $display("FAIL int_entry: got R=%b T=%h want 1 01", R, T); end
    repeat (2) tick();
    total++; if ({R, T} !== {1'b1, 8'h04}) begin bad++; $display("FAIL int_rt2: got R=%b T=%h want 1 04", R, T); end
    tick();
    total++; if ({R, IEN, T, D} !== {2'b00, 8'h01, 8'h04}) begin bad++; $display("FAIL int_exit: got R=%b IEN=%b T=%h D=%h want 0 0 01 04", R, IEN, T, D); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++; if ({out_valid, FGO} !== 2'b01) begin bad++; $display("FAIL int_out_done: got ov=%b FGO=%b want 0 1", out_valid, FGO); end
    run_to_t0();
  endtask

  task automatic test_out();
    ir_op = 3'd7; ir_i = 1'b1; ir_b = 12'h400; out_ready = 1'b0;
    repeat (4) tick();
    ir_b = 12'h100;
    total++; if ({FGO, out_valid} !== 2'b01) begin bad++; $display("FAIL out_load: got FGO=%b ov=%b want 0 1", FGO, out_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if ({FGO, out_valid} !== 2'b01) begin bad++; $display("FAIL out_hold%0d: got FGO=%b ov=%b want 0 1", k, FGO, out_valid); end
    end
    total++; if (skip !== 1'b0) begin bad++; $display("FAIL sko_clear: got %b want 0", skip); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++; if ({FGO, out_valid, T} !== {2'b10, 8'h01}) begin bad++; $display("FAIL out_done: got FGO=%b ov=%b T=%h want 1 0 01", FGO, out_valid, T); end
    repeat (3) tick();
    total++; if (skip !== 1'b1) begin bad++; $display("FAIL sko_set: got %b want 1", skip); end
    tick();
  endtask

  task automatic test_isz();
    ir_op = 3'd6; ir_i = 1'b0; ir_b = 12'h000; dr_zero = 1'b1;
    repeat (6) tick();
    total++; if ({T, skip} !== {8'h40, 1'b1}) begin bad++; $display("FAIL isz_skip: got T=%h skip=%b want 40 1", T, skip); end
    tick();
    dr_zero = 1'b0;
    total++; if ({T, skip} !== {8'h01, 1'b0}) begin bad++; $display("FAIL isz_next: got T=%h skip=%b want 01 0", T, skip); end
  endtask

  task automatic test_rst_mid();
    ir_op = 3'd7; ir_i = 1'b1; ir_b = 12'h400; out_ready = 1'b0;
    repeat (4) tick();
    ir_op = 3'd6; ir_i = 1'b0; ir_b = 12'h000;
    repeat (4) tick();
    total++; if ({T, D, out_valid} !== {8'h10, 8'h40, 1'b1}) begin bad++; $display("FAIL isz_t4: got T=%h D=%h ov=%b want 10 40 1", T, D, out_valid); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if ({T, D, out_valid, FGO, FGI, R, IEN, S} !== {8'h01, 8'h00, 6'b010001}) begin bad++; $display("FAIL rst_mid: got T=%h D=%h ov=%b FGO=%b FGI=%b R=%b IEN=%b S=%b", T, D, out_valid, FGO, FGI, R, IEN, S); end
  endtask

  initial begin
    rst = 1'b1; ir_op = 3'd0; ir_i = 1'b0; ir_b = 12'h000;
    ac_sign = 1'b0; ac_zero = 1'b0; e_flag = 1'b0; dr_zero = 1'b0;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_lda_walk();
    test_reg_skip();
    test_hlt_start();
    test_interrupt();
    test_out();
    test_isz();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
